rvfi_commit_checker: RTL and testbench
======================================

// Module: rvfi_commit_checker
// PURPOSE
//  Consumer end of the RVFI commit stream that the pipeline/testbench side produces.
//  Samples one retirement packet per cycle when commit=1 and keeps a shadow x0-x31 register file.
//  Checks order continuity, PC continuity, operand data, x0 writes, mem masks, halt and forward progress.
//  Reports sticky error flags, the first failing order and retirement statistics to the mp3 bench.
// PARAMETERS
//  RESET_PC        32'h0000_0060  pc_rdata required on the first commit after reset
//  TIMEOUT_CYCLES  10000          max cycles between commits before a timeout error (>=1)
//  ORDER_W         64             width of order / counters
// PORTS
//  clk             in   1        rising-edge clock
//  rst             in   1        reset, asynchronous, active-low
//  commit          in   1        packet valid this cycle
//  order           in   ORDER_W  retirement index of the packet
//  inst            in   32       retired instruction word
//  pc_rdata        in   32       PC of retired instruction
//  pc_wdata        in   32       next PC after the instruction
//  rs1_addr        in   5        source 1 index
//  rs2_addr        in   5        source 2 index
//  rs1_rdata       in   32       source 1 value used
//  rs2_rdata       in   32       source 2 value used
//  load_regfile    in   1        instruction writes rd
//  rd_addr         in   5        destination index
//  rd_wdata        in   32       destination value
//  mem_rmask       in   4        load byte mask
//  mem_wmask       in   4        store byte mask
//  halt            in   1        halt indication (qualified by commit)
//  err             out  1        sticky, OR of errcode
//  errcode         out  8        sticky per-check flags, bit map below
//  first_err_order out  ORDER_W  order of the first failing packet (0 if none)
//  commit_count    out  ORDER_W  packets accepted
//  halted          out  1        halt commit accepted
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs 0, shadow regs 0, state WAIT_FIRST, timeout counter 0.
//  - FSM: WAIT_FIRST -commit-> RUN; RUN -commit&halt-> HALTED; HALTED is terminal until reset.
//  - All checks run only on cycles with commit=1; updates register on the same clk edge.
//  - Outputs reflect a packet 1 cycle after its sampling edge.
//  - errcode[0] ORDER: WAIT_FIRST needs order==0; RUN needs order==last_order+1, mod 2^ORDER_W.
//  - errcode[1] PC: WAIT_FIRST needs pc_rdata==RESET_PC; RUN needs pc_rdata==last pc_wdata.
//  - errcode[2] RS1 / errcode[3] RS2: rdata differs from shadow[addr]; shadow[0] is 0.
//  - Operand compare uses the shadow BEFORE this packet's rd update (addi x1,x1,1 legal).
//  - errcode[4] X0: load_regfile & rd_addr==0 & rd_wdata!=0.
//  - errcode[5] TIMEOUT: counter clears on commit and is frozen in HALTED.
//  - errcode[5] also fires if counter reaches TIMEOUT_CYCLES in WAIT_FIRST/RUN; counter then saturates.
//  - errcode[6] MASK: mem_rmask!=0 and mem_wmask!=0 in one packet.
//  - errcode[7] POST_HALT: any commit while in HALTED; packet otherwise ignored.
//  - Shadow update: load_regfile & rd_addr!=0 -> shadow[rd_addr]<=rd_wdata, also when the packet errs.
//  - commit_count increments per commit in WAIT_FIRST/RUN and saturates at all-ones.
//  - last_order / last pc_wdata update on every accepted commit, even if it failed.
//  - first_err_order latches only when err goes 0->1; later errors only set errcode bits.
//  - halted=1 from the edge that samples commit&halt; that packet is still fully checked.
//  - commit=0: no state change apart from the timeout counter.
// TESTING
//  - Reset, 3 commits order 0,1,2, pc 0x60->0x64->0x68->0x6C, no writes -> err=0, commit_count=3.
//  - addi x1,x1,1 x3: rs1_rdata 0,1,2 / rd_wdata 1,2,3 -> err=0; then rs1_rdata=5 on x1 -> errcode=8'h04, first_err_order=3.
//  - Order 0,1,3 -> errcode[0]=1, first_err_order=3; then pc_rdata!=prev pc_wdata -> errcode=8'h03, first_err_order still 3.
//  - load_regfile=1, rd_addr=0, rd_wdata=0xDEAD -> errcode[4]=1; next rs1_addr=0, rs1_rdata=0 -> no RS1 error.
//  - TIMEOUT_CYCLES=16, no commit for 16 cycles after first commit -> errcode[5]=1 on cycle 16; halt commit then idle 100 cycles -> no change, halted=1.
//  - rst low mid-run with err=1 -> all outputs 0 asynchronously; resume from order 0, pc 0x60 -> clean.

Source files
------------

// File: rtl/rvfi_commit_checker.sv
// RVFI commit-stream checker: keeps a shadow register file and flags order, PC,
// operand, x0, mask, timeout and post-halt violations as sticky error bits.
module rvfi_commit_checker #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0060,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned ORDER_W        = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               commit,
  input  logic [ORDER_W-1:0] order,
  input  logic [31:0]        inst,
  input  logic [31:0]        pc_rdata,
  input  logic [31:0]        pc_wdata,
  input  logic [4:0]         rs1_addr,
  input  logic [4:0]         rs2_addr,
  input  logic [31:0]        rs1_rdata,
  input  logic [31:0]        rs2_rdata,
  input  logic               load_regfile,
  input  logic [4:0]         rd_addr,
  input  logic [31:0]        rd_wdata,
  input  logic [3:0]         mem_rmask,
  input  logic [3:0]         mem_wmask,
  input  logic               halt,
  output logic               err,
  output logic [7:0]         errcode,
  output logic [ORDER_W-1:0] first_err_order,
  output logic [ORDER_W-1:0] commit_count,
  output logic               halted
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    WAIT_FIRST,
    RUN,
    HALTED
  } state_t;

  state_t             state, state_next;
  logic [31:0]        shadow [32];
  logic [ORDER_W-1:0] last_order;
  logic [31:0]        last_pc;
  logic [CNT_W-1:0]   idle_cnt;
  logic [7:0]         new_err;
  logic               accept;
  logic [31:0]        rs1_shadow, rs2_shadow;

  // The instruction word is carried for trace completeness but never checked.
  logic unused_inst;
  assign unused_inst = ^inst;

  assign accept     = commit && (state != HALTED);
  // Entry 0 is never written, so reading it always yields zero.
  assign rs1_shadow = shadow[rs1_addr];
  assign rs2_shadow = shadow[rs2_addr];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    new_err    = 8'h00;
    if (commit) begin
      if (state == HALTED) begin
        new_err[7] = 1'b1;
      end else begin
        if (state == WAIT_FIRST) begin
          new_err[0] = (order != '0);
          new_err[1] = (pc_rdata != RESET_PC);
        end else begin
          new_err[0] = (order != last_order + 1'b1);
          new_err[1] = (pc_rdata != last_pc);
        end
        new_err[2] = (rs1_rdata != rs1_shadow);
        new_err[3] = (rs2_rdata != rs2_shadow);
        new_err[4] = load_regfile && (rd_addr == 5'd0) && (rd_wdata != 32'd0);
        new_err[6] = (mem_rmask != 4'h0) && (mem_wmask != 4'h0);
        state_next = halt ? HALTED : RUN;
      end
    end else if ((state != HALTED) && (idle_cnt == CNT_LAST)) begin
      new_err[5] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= WAIT_FIRST;
      errcode         <= 8'h00;
      first_err_order <= '0;
      commit_count    <= '0;
      last_order      <= '0;
      last_pc         <= 32'd0;
      idle_cnt        <= '0;
    end else begin
      state   <= state_next;
      errcode <= errcode | new_err;
      if (commit && !err && (new_err != 8'h00)) begin
        first_err_order <= order;
      end
      if (state != HALTED) begin
        if (commit) begin
          idle_cnt <= '0;
        end else if (idle_cnt != CNT_MAX) begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
      if (accept) begin
        last_order <= order;
        last_pc    <= pc_wdata;
        if (commit_count != '1) begin
          commit_count <= commit_count + 1'b1;
        end
      end
    end
  end

  // NOTE: the shadow file is reset because operand checks must see zeros after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        shadow[i] <= 32'd0;
      end
    end else if (accept && load_regfile && (rd_addr != 5'd0)) begin
      shadow[rd_addr] <= rd_wdata;
    end
  end

  assign err    = |errcode;
  assign halted = (state == HALTED);

endmodule

// File: tb/tb_rvfi_commit_checker.sv
// Self-checking bench for rvfi_commit_checker: directed scenarios plus randomized
// packets compared against a spec-level reference model.
module tb_rvfi_commit_checker;

  localparam logic [31:0] RESET_PC = 32'h0000_0060;
  localparam int          TMO      = 16;

  typedef struct {
    logic [63:0] order;
    logic [31:0] inst, pc, npc, rs1d, rs2d, rdw;
    logic [4:0]  rs1a, rs2a, rd;
    logic        ld, halt;
    logic [3:0]  rm, wm;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        commit = 1'b0;
  logic [63:0] order = '0;
  logic [31:0] inst = '0, pc_rdata = '0, pc_wdata = '0;
  logic [4:0]  rs1_addr = '0, rs2_addr = '0, rd_addr = '0;
  logic [31:0] rs1_rdata = '0, rs2_rdata = '0, rd_wdata = '0;
  logic        load_regfile = 1'b0, halt = 1'b0;
  logic [3:0]  mem_rmask = '0, mem_wmask = '0;
  logic        err, halted;
  logic [7:0]  errcode;
  logic [63:0] first_err_order, commit_count;

  rvfi_commit_checker #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(TMO), .ORDER_W(64)) dut (
    .clk(clk), .rst(rst), .commit(commit), .order(order), .inst(inst),
    .pc_rdata(pc_rdata), .pc_wdata(pc_wdata), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata), .load_regfile(load_regfile),
    .rd_addr(rd_addr), .rd_wdata(rd_wdata), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .halt(halt), .err(err), .errcode(errcode), .first_err_order(first_err_order),
    .commit_count(commit_count), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the checker's rules written as plain bookkeeping.
  logic [31:0] m_reg [32];
  bit          m_seen, m_halted;
  logic [63:0] m_last_order, m_first, m_count;
  logic [31:0] m_last_pc;
  logic [7:0]  m_code;
  int          m_idle;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    m_seen = 0; m_halted = 0; m_last_order = '0; m_first = '0; m_count = '0;
    m_last_pc = '0; m_code = '0; m_idle = 0;
  endtask

  task automatic model_commit(input pkt_t p);
    logic [7:0] bits;
    bits = '0;
    if (m_halted) begin
      bits = 8'h80;
    end else begin
      if (m_seen) begin
        if (p.order != m_last_order + 64'd1) bits |= 8'h01;
        if (p.pc != m_last_pc) bits |= 8'h02;
      end else begin
        if (p.order != 64'd0) bits |= 8'h01;
        if (p.pc != RESET_PC) bits |= 8'h02;
      end
      if (p.rs1d != m_reg[p.rs1a]) bits |= 8'h04;
      if (p.rs2d != m_reg[p.rs2a]) bits |= 8'h08;
      if (p.ld && p.rd == 0 && p.rdw != 0) bits |= 8'h10;
      if (p.rm != 0 && p.wm != 0) bits |= 8'h40;
      if (p.ld && p.rd != 0) m_reg[p.rd] = p.rdw;
      m_last_order = p.order;
      m_last_pc = p.npc;
      if (m_count != '1) m_count++;
      m_seen = 1;
      m_idle = 0;
      if (p.halt) m_halted = 1;
    end
    if (m_code == 0 && bits != 0) m_first = p.order;
    m_code |= bits;
  endtask

  task automatic model_idle();
    if (!m_halted && m_idle < TMO) begin
      m_idle++;
      if (m_idle == TMO) m_code |= 8'h20;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".err"}, 64'(err), 64'(m_code != 0));
    check({tag, ".errcode"}, 64'(errcode), 64'(m_code));
    check({tag, ".first_err_order"}, first_err_order, m_first);
    check({tag, ".commit_count"}, commit_count, m_count);
    check({tag, ".halted"}, 64'(halted), 64'(m_halted));
  endtask

  task automatic send(input pkt_t p, input string tag);
    commit = 1'b1; order = p.order; inst = p.inst; pc_rdata = p.pc; pc_wdata = p.npc;
    rs1_addr = p.rs1a; rs1_rdata = p.rs1d; rs2_addr = p.rs2a; rs2_rdata = p.rs2d;
    load_regfile = p.ld; rd_addr = p.rd; rd_wdata = p.rdw;
    mem_rmask = p.rm; mem_wmask = p.wm; halt = p.halt;
    @(posedge clk);
    model_commit(p);
    #1;
    commit = 1'b0;
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_idle();
      #1;
      check_outputs(tag);
    end
  endtask

  task automatic do_reset();
    commit = 1'b0;
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  function automatic pkt_t mk(input logic [63:0] o, input logic [31:0] pc, input logic [31:0] npc);
    pkt_t p;
    p.order = o; p.inst = 32'h0000_0013; p.pc = pc; p.npc = npc;
    p.rs1a = 0; p.rs1d = 0; p.rs2a = 0; p.rs2d = 0; p.rd = 0; p.rdw = 0;
    p.ld = 0; p.halt = 0; p.rm = 0; p.wm = 0;
    return p;
  endfunction

  function automatic pkt_t addi_x1(input logic [63:0] o, input logic [31:0] v);
    pkt_t p;
    p = mk(o, 32'h60 + 32'(o) * 4, 32'h64 + 32'(o) * 4);
    p.inst = 32'h0010_8093; p.rs1a = 1; p.rs1d = v; p.ld = 1; p.rd = 1; p.rdw = v + 1;
    return p;
  endfunction

  function automatic pkt_t rand_pkt();
    pkt_t p;
    logic [63:0] o;
    logic [31:0] pc;
    o  = m_seen ? m_last_order + 64'd1 : 64'd0;
    pc = m_seen ? m_last_pc : RESET_PC;
    p = mk(o, pc, ($urandom_range(0, 5) == 0) ? ($urandom() & 32'hFFFF_FFFC) : pc + 4);
    if ($urandom_range(0, 14) == 0) p.order = o + 64'd2;
    if ($urandom_range(0, 14) == 0) p.pc = pc ^ 32'h4;
    p.inst = $urandom();
    p.rs1a = 5'($urandom()); p.rs1d = m_reg[p.rs1a];
    p.rs2a = 5'($urandom()); p.rs2d = m_reg[p.rs2a];
    if ($urandom_range(0, 14) == 0) p.rs1d ^= 32'h1;
    if ($urandom_range(0, 14) == 0) p.rs2d ^= 32'h8000_0000;
    p.ld = 1'($urandom()); p.rd = 5'($urandom()); p.rdw = $urandom();
    if (p.rd == 0 && $urandom_range(0, 1) == 0) p.rdw = 0;
    if ($urandom_range(0, 1) == 0) p.rm = 4'($urandom()); else p.wm = 4'($urandom());
    if ($urandom_range(0, 14) == 0) begin p.rm = 4'h1; p.wm = 4'h2; end
    p.halt = m_seen && ($urandom_range(0, 39) == 0);
    return p;
  endfunction

  initial begin
    pkt_t p;
    do_reset();
    #1 check_outputs("reset");

    // Three clean commits with no register writes.
    for (int i = 0; i < 3; i++) send(mk(i, 32'h60 + i * 4, 32'h64 + i * 4), "seq3");
    check("seq3.err_const", 64'(err), 64'd0);
    check("seq3.count_const", commit_count, 64'd3);

    // addi x1,x1,1 chain, then a stale x1 operand.
    do_reset();
    for (int i = 0; i < 3; i++) send(addi_x1(i, i), "addi");
    check("addi.clean", 64'(errcode), 64'h00);
    send(addi_x1(3, 5), "addi_bad");
    check("addi_bad.code_const", 64'(errcode), 64'h04);
    check("addi_bad.first_const", first_err_order, 64'd3);

    // Order gap, then a PC discontinuity.
    do_reset();
    send(mk(0, 32'h60, 32'h64), "ord");
    send(mk(1, 32'h64, 32'h68), "ord");
    send(mk(3, 32'h68, 32'h6C), "ord_gap");
    check("ord_gap.code_const", 64'(errcode), 64'h01);
    check("ord_gap.first_const", first_err_order, 64'd3);
    send(mk(4, 32'h100, 32'h104), "pc_bad");
    check("pc_bad.code_const", 64'(errcode), 64'h03);
    check("pc_bad.first_const", first_err_order, 64'd3);

    // Nonzero write to x0; x0 must still read as zero.
    do_reset();
    p = mk(0, 32'h60, 32'h64); p.ld = 1; p.rd = 0; p.rdw = 32'hDEAD;
    send(p, "x0_write");
    check("x0_write.code_const", 64'(errcode), 64'h10);
    p = mk(1, 32'h64, 32'h68); p.rs1a = 0; p.rs1d = 0;
    send(p, "x0_read");
    check("x0_read.code_const", 64'(errcode), 64'h10);

    // Timeout boundary, then halt and long idle, then a post-halt commit.
    do_reset();
    send(mk(0, 32'h60, 32'h64), "tmo");
    idle(TMO - 1, "tmo_wait");
    check("tmo_wait.code_const", 64'(errcode), 64'h00);
    idle(1, "tmo_hit");
    check("tmo_hit.code_const", 64'(errcode), 64'h20);
    p = mk(1, 32'h64, 32'h68); p.halt = 1;
    send(p, "halt");
    idle(100, "halt_idle");
    check("halt_idle.halted_const", 64'(halted), 64'd1);
    check("halt_idle.code_const", 64'(errcode), 64'h20);
    send(mk(2, 32'h68, 32'h6C), "post_halt");
    check("post_halt.code_const", 64'(errcode), 64'hA0);

    // Asynchronous reset in mid-run with an error pending, then a clean restart.
    do_reset();
    send(mk(0, 32'h60, 32'h64), "arst");
    send(mk(5, 32'h64, 32'h68), "arst_err");
    #1 rst = 1'b0;
    model_reset();
    #1 check_outputs("arst_async");
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) send(mk(i, 32'h60 + i * 4, 32'h64 + i * 4), "arst_resume");
    check("arst_resume.err_const", 64'(err), 64'd0);

    // Randomized traffic in several reset rounds.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int k = 0; k < 60; k++) begin
        if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 20), $sformatf("rnd%0d_idle", r));
        else send(rand_pkt(), $sformatf("rnd%0d_pkt%0d", r, k));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
